// File: rtl/dcache_wbuf.sv
// dcache_wbuf: in-order write buffer between the dcache and the AXI bridge.
// Queues dirty-line evictions and uncached stores, drains them on wr_req/wr_rdy,
// and answers same-line probes so a refill never overtakes a pending write.
// Optional feature macro: WBUF_FWD_EN (forward a word from the newest matching line entry).
module dcache_wbuf #(
  parameter int DEPTH      = 4,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push_valid,
  output logic                      push_ready,
  input  logic [2:0]                push_type,
  input  logic [ADDR_W-1:0]         push_addr,
  input  logic [3:0]                push_wstrb,
  input  logic [32*LINE_WORDS-1:0]  push_data,
  output logic                      wr_req,
  output logic [2:0]                wr_type,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [3:0]                wr_wstrb,
  output logic [32*LINE_WORDS-1:0]  wr_data,
  input  logic                      wr_rdy,
  input  logic [ADDR_W-1:0]         lookup_addr,
  output logic                      lookup_hit,
  output logic                      lookup_fwd,
  output logic [31:0]               lookup_data,
  input  logic                      flush,
  output logic                      wbuf_empty,
  output logic [$clog2(DEPTH):0]    wbuf_count
);

  localparam int OFF    = $clog2(LINE_WORDS * 4);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int DATA_W = 32 * LINE_WORDS;

  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [DEPTH-1:0]  valid;
  logic              push_fire;
  logic              pop_fire;
  logic [DEPTH-1:0]  match;

  logic [2:0]        mem_type  [DEPTH];
  logic [ADDR_W-1:0] mem_addr  [DEPTH];
  logic [3:0]        mem_wstrb [DEPTH];
  logic [DATA_W-1:0] mem_data  [DEPTH];

  // A full buffer refuses pushes even when the head pops this cycle.
  assign push_ready = (count < CNT_W'(DEPTH)) && !flush;
  assign push_fire  = push_valid && push_ready;
  assign wr_req     = (count != '0);
  assign pop_fire   = wr_req && wr_rdy;
  assign wbuf_empty = !wr_req;
  assign wbuf_count = count;

  // Pointer, occupancy and per-entry valid bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      if (push_fire) begin
        wr_ptr        <= wr_ptr + 1'b1;
        valid[wr_ptr] <= 1'b1;
      end
      if (pop_fire) begin
        rd_ptr        <= rd_ptr + 1'b1;
        valid[rd_ptr] <= 1'b0;
      end
      case ({push_fire, pop_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry payload storage, written at wr_ptr on an accepted push.
  always_ff @(posedge clk) begin
    // NOTE: payload storage has no reset; valid bits gate every use, so stale contents never leak out.
    if (push_fire) begin
      mem_type[wr_ptr]  <= push_type;
      mem_addr[wr_ptr]  <= push_addr;
      mem_wstrb[wr_ptr] <= push_wstrb;
      mem_data[wr_ptr]  <= push_data;
    end
  end

  // Head entry toward the bus, forced to zero while the buffer is empty.
  always_comb begin
    wr_type  = '0;
    wr_addr  = '0;
    wr_wstrb = '0;
    wr_data  = '0;
    if (wr_req) begin
      wr_type  = mem_type[rd_ptr];
      wr_addr  = mem_addr[rd_ptr];
      wr_wstrb = mem_wstrb[rd_ptr];
      wr_data  = mem_data[rd_ptr];
    end
  end

  // Line-address comparison of the probe against every valid entry.
  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = valid[i] && (mem_addr[i][ADDR_W-1:OFF] == lookup_addr[ADDR_W-1:OFF]);
    end
  end

  assign lookup_hit = |match;

`ifdef WBUF_FWD_EN
  localparam int WSEL_W = (OFF > 2) ? OFF - 2 : 1;

  logic [PTR_W-1:0]  newest_idx;
  logic [PTR_W-1:0]  scan_idx;
  logic [WSEL_W-1:0] word_sel;
  logic [DATA_W-1:0] newest_line;

  // Walk entries oldest to newest so the last match seen is the newest one.
  always_comb begin
    newest_idx = '0;
    scan_idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = rd_ptr + PTR_W'(k);
      if (match[scan_idx]) newest_idx = scan_idx;
    end
  end

  // Forward the probed word only when the newest match is a full line.
  always_comb begin
    word_sel    = WSEL_W'(lookup_addr >> 2) & WSEL_W'(LINE_WORDS - 1);
    newest_line = mem_data[newest_idx];
    lookup_fwd  = 1'b0;
    lookup_data = '0;
    if (lookup_hit && (mem_type[newest_idx] == 3'b100)) begin
      lookup_fwd  = 1'b1;
      lookup_data = newest_line[32*word_sel +: 32];
    end
  end
`else
  assign lookup_fwd  = 1'b0;
  assign lookup_data = '0;
`endif

endmodule

// File: tb/tb_dcache_wbuf.sv
// tb_dcache_wbuf: directed and randomized checks of dcache_wbuf against a queue model.
module tb_dcache_wbuf;

  localparam int DEPTH      = 4;
  localparam int LINE_WORDS = 4;
  localparam int ADDR_W     = 32;
  localparam int OFF        = $clog2(LINE_WORDS * 4);
  localparam int DW         = 32 * LINE_WORDS;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          push_valid = 1'b0;
  logic          push_ready;
  logic [2:0]    push_type = '0;
  logic [31:0]   push_addr = '0;
  logic [3:0]    push_wstrb = '0;
  logic [DW-1:0] push_data = '0;
  logic          wr_req;
  logic [2:0]    wr_type;
  logic [31:0]   wr_addr;
  logic [3:0]    wr_wstrb;
  logic [DW-1:0] wr_data;
  logic          wr_rdy = 1'b0;
  logic [31:0]   lookup_addr = '0;
  logic          lookup_hit;
  logic          lookup_fwd;
  logic [31:0]   lookup_data;
  logic          flush = 1'b0;
  logic          wbuf_empty;
  logic [2:0]    wbuf_count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0]    t;
    logic [31:0]   a;
    logic [3:0]    s;
    logic [DW-1:0] d;
  } ent_t;

  ent_t q[$];

  dcache_wbuf #(.DEPTH(DEPTH), .LINE_WORDS(LINE_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .push_valid(push_valid), .push_ready(push_ready), .push_type(push_type),
    .push_addr(push_addr), .push_wstrb(push_wstrb), .push_data(push_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_fwd(lookup_fwd),
    .lookup_data(lookup_data), .flush(flush),
    .wbuf_empty(wbuf_empty), .wbuf_count(wbuf_count)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] l;
    for (int i = 0; i < LINE_WORDS; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  // Reference lookup: newest queued entry on the same line decides hit/forward.
  function automatic void model_lookup(input logic [31:0] a, output logic h,
                                       output logic f, output logic [31:0] d);
    h = 1'b0; f = 1'b0; d = '0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if ((q[i].a >> OFF) == (a >> OFF)) begin
        h = 1'b1;
`ifdef WBUF_FWD_EN
        if (q[i].t == 3'b100) begin
          f = 1'b1;
          d = q[i].d[32*((a >> 2) % LINE_WORDS) +: 32];
        end
`endif
        break;
      end
    end
  endfunction

  // One clock: decide push/pop from the FIFO rules, then update the model after the edge.
  task automatic tick();
    bit   do_push, do_pop;
    ent_t e;
    do_push = push_valid && (q.size() < DEPTH) && !flush;
    do_pop  = (q.size() != 0) && wr_rdy;
    e = '{push_type, push_addr, push_wstrb, push_data};
    @(posedge clk);
    if (do_pop) q.delete(0);
    if (do_push) q.push_back(e);
    #1;
  endtask

  task automatic idle_inputs();
    push_valid = 1'b0; wr_rdy = 1'b0; flush = 1'b0; lookup_addr = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    #1;
    q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic push_set(input logic [2:0] t, input logic [31:0] a,
                          input logic [3:0] s, input logic [DW-1:0] d);
    push_valid = 1'b1; push_type = t; push_addr = a; push_wstrb = s; push_data = d;
  endtask

  task automatic test_reset();
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (wr_req !== 1'b0) begin n_fail++; $display("FAIL reset_wr_req: got %0b want 0", wr_req); end
    n_checks++; if (wbuf_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %0b want 1", wbuf_empty); end
    n_checks++; if (wbuf_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", wbuf_count); end
    n_checks++; if (push_ready !== 1'b1) begin n_fail++; $display("FAIL reset_push_ready: got %0b want 1", push_ready); end
    n_checks++; if ({lookup_hit, lookup_fwd} !== 2'b00 || lookup_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_lookup: got hit=%0b fwd=%0b data=%h want 0/0/0", lookup_hit, lookup_fwd, lookup_data); end
    n_checks++; if (wr_type !== 3'd0 || wr_addr !== 32'h0 || wr_wstrb !== 4'h0 || wr_data !== '0) begin
      n_fail++; $display("FAIL reset_wr_fields: got type=%0h addr=%h wstrb=%h want zeros", wr_type, wr_addr, wr_wstrb); end
    reset = 1'b0;
    #1;
  endtask

  task automatic test_single_line();
    logic [DW-1:0] d;
    d = rand_line();
    push_set(3'b100, 32'h1000_0040, 4'hF, d);
    tick();
    push_valid = 1'b0;
    #1;
    n_checks++; if (wr_req !== 1'b1) begin n_fail++; $display("FAIL single_wr_req: got %0b want 1", wr_req); end
    n_checks++; if (wr_addr !== 32'h1000_0040) begin n_fail++; $display("FAIL single_addr: got %h want 10000040", wr_addr); end
    n_checks++; if (wr_type !== 3'b100) begin n_fail++; $display("FAIL single_type: got %b want 100", wr_type); end
    n_checks++; if (wr_data !== d) begin n_fail++; $display("FAIL single_data: got %h want %h", wr_data, d); end
    n_checks++; if (wbuf_count !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", wbuf_count); end
    wr_rdy = 1'b1;
    tick();
    wr_rdy = 1'b0;
    #1;
    n_checks++; if (wr_req !== 1'b0 || wbuf_empty !== 1'b1) begin
      n_fail++; $display("FAIL single_drained: got wr_req=%0b empty=%0b want 0/1", wr_req, wbuf_empty); end
  endtask

  task automatic test_fill_drain();
    logic [31:0] exp_a[4];
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      exp_a[i] = 32'h4000_0000 + 32'(i) * 32'h100 + ($urandom & 32'hC);
      push_set(3'(i % 3), exp_a[i], 4'($urandom), rand_line());
      tick();
    end
    push_valid = 1'b0;
    #1;
    n_checks++; if (wbuf_count !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d want 4", wbuf_count); end
    n_checks++; if (push_ready !== 1'b0) begin n_fail++; $display("FAIL fill_push_ready: got %0b want 0", push_ready); end
    push_set(3'b100, 32'h5555_0000, 4'hF, rand_line());
    tick();
    push_valid = 1'b0;
    #1;
    n_checks++; if (wbuf_count !== 3'd4 || wr_addr !== exp_a[0]) begin
      n_fail++; $display("FAIL fill_overflow: got count=%0d head=%h want 4/%h", wbuf_count, wr_addr, exp_a[0]); end
    wr_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (wr_req !== 1'b1 || wr_addr !== exp_a[i]) begin
        n_fail++; $display("FAIL drain_order_%0d: got req=%0b addr=%h want 1/%h", i, wr_req, wr_addr, exp_a[i]); end
      tick();
    end
    wr_rdy = 1'b0;
    #1;
    n_checks++; if (wbuf_empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %0b want 1", wbuf_empty); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    push_set(3'b010, 32'h6000_0000, 4'h1, rand_line()); tick();
    push_set(3'b010, 32'h6000_0100, 4'h2, rand_line()); tick();
    push_set(3'b100, 32'h6000_0200, 4'hF, rand_line());
    wr_rdy = 1'b1;
    #1;
    n_checks++; if (push_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %0b want 1", push_ready); end
    tick();
    push_valid = 1'b0; wr_rdy = 1'b0;
    #1;
    n_checks++; if (wbuf_count !== 3'd2 || wr_addr !== 32'h6000_0100) begin
      n_fail++; $display("FAIL b2b_count: got count=%0d head=%h want 2/60000100", wbuf_count, wr_addr); end
    wr_rdy = 1'b1; tick(); #1;
    n_checks++; if (wr_addr !== 32'h6000_0200 || wr_type !== 3'b100) begin
      n_fail++; $display("FAIL b2b_third: got addr=%h type=%b want 60000200/100", wr_addr, wr_type); end
    tick();
    // Full buffer: a pop in the same cycle does not free a slot for the push.
    wr_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin push_set(3'b010, 32'h6100_0000 + 32'(i) * 32'h40, 4'hF, rand_line()); tick(); end
    push_set(3'b010, 32'h6200_0000, 4'hF, rand_line());
    wr_rdy = 1'b1;
    tick();
    push_valid = 1'b0; wr_rdy = 1'b0;
    #1;
    n_checks++; if (wbuf_count !== 3'd3) begin n_fail++; $display("FAIL full_pushpop: got count=%0d want 3", wbuf_count); end
  endtask

  task automatic test_lookup();
    logic [DW-1:0] d1, d2;
    apply_reset();
    d1 = rand_line();
    d2 = rand_line();
    push_set(3'b100, 32'h2000_0010, 4'hF, d1);
    lookup_addr = 32'h2000_001C;
    #1;
    n_checks++; if (lookup_hit !== 1'b0) begin n_fail++; $display("FAIL lookup_same_cycle_push: got %0b want 0", lookup_hit); end
    tick();
    push_valid = 1'b0;
    #1;
    n_checks++; if (lookup_hit !== 1'b1) begin n_fail++; $display("FAIL lookup_hit: got %0b want 1", lookup_hit); end
`ifdef WBUF_FWD_EN
    n_checks++; if (lookup_fwd !== 1'b1 || lookup_data !== d1[127:96]) begin
      n_fail++; $display("FAIL lookup_fwd_w3: got fwd=%0b data=%h want 1/%h", lookup_fwd, lookup_data, d1[127:96]); end
`else
    n_checks++; if (lookup_fwd !== 1'b0 || lookup_data !== 32'h0) begin
      n_fail++; $display("FAIL lookup_nofwd: got fwd=%0b data=%h want 0/0", lookup_fwd, lookup_data); end
`endif
    lookup_addr = 32'h2000_0020;
    #1;
    n_checks++; if (lookup_hit !== 1'b0) begin n_fail++; $display("FAIL lookup_next_line: got %0b want 0", lookup_hit); end
    push_set(3'b100, 32'h2000_0018, 4'hF, d2);
    tick();
    push_valid = 1'b0;
    lookup_addr = 32'h2000_0014;
    #1;
`ifdef WBUF_FWD_EN
    n_checks++; if (lookup_fwd !== 1'b1 || lookup_data !== d2[63:32]) begin
      n_fail++; $display("FAIL lookup_newest: got fwd=%0b data=%h want 1/%h", lookup_fwd, lookup_data, d2[63:32]); end
`else
    n_checks++; if (lookup_hit !== 1'b1 || lookup_data !== 32'h0) begin
      n_fail++; $display("FAIL lookup_two: got hit=%0b data=%h want 1/0", lookup_hit, lookup_data); end
`endif
    push_set(3'b010, 32'h2000_0014, 4'h3, rand_line());
    tick();
    push_valid = 1'b0;
    #1;
    n_checks++; if (lookup_hit !== 1'b1 || lookup_fwd !== 1'b0) begin
      n_fail++; $display("FAIL lookup_newest_word: got hit=%0b fwd=%0b want 1/0", lookup_hit, lookup_fwd); end
    // Drain to the last entry; an entry popping this cycle stays visible.
    wr_rdy = 1'b1; tick(); tick();
    #1;
    n_checks++; if (lookup_hit !== 1'b1 || wbuf_count !== 3'd1) begin
      n_fail++; $display("FAIL lookup_popping: got hit=%0b count=%0d want 1/1", lookup_hit, wbuf_count); end
    tick();
    wr_rdy = 1'b0;
    #1;
    n_checks++; if (lookup_hit !== 1'b0) begin n_fail++; $display("FAIL lookup_after_pop: got %0b want 0", lookup_hit); end
  endtask

  task automatic test_uncached();
    apply_reset();
    push_set(3'b010, 32'hBFD0_0000, 4'b0011, rand_line());
    tick();
    push_valid = 1'b0;
    lookup_addr = 32'hBFD0_0000;
    #1;
    n_checks++; if (wr_type !== 3'b010 || wr_wstrb !== 4'b0011 || wr_addr !== 32'hBFD0_0000) begin
      n_fail++; $display("FAIL uncached_fields: got type=%b wstrb=%b addr=%h want 010/0011/bfd00000", wr_type, wr_wstrb, wr_addr); end
    n_checks++; if (lookup_hit !== 1'b1 || lookup_fwd !== 1'b0 || lookup_data !== 32'h0) begin
      n_fail++; $display("FAIL uncached_lookup: got hit=%0b fwd=%0b data=%h want 1/0/0", lookup_hit, lookup_fwd, lookup_data); end
    wr_rdy = 1'b1; tick(); wr_rdy = 1'b0;
  endtask

  task automatic test_flush_reset();
    logic [31:0] a[3];
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      a[i] = 32'h7000_0000 + 32'(i) * 32'h20;
      push_set(3'b100, a[i], 4'hF, rand_line());
      tick();
    end
    flush = 1'b1;
    push_set(3'b100, 32'h7100_0000, 4'hF, rand_line());
    wr_rdy = 1'b1;
    #1;
    n_checks++; if (push_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %0b want 0", push_ready); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (wr_addr !== a[i]) begin n_fail++; $display("FAIL flush_pop_%0d: got %h want %h", i, wr_addr, a[i]); end
      tick();
    end
    n_checks++; if (wbuf_empty !== 1'b1 || wbuf_count !== 3'd0) begin
      n_fail++; $display("FAIL flush_empty: got empty=%0b count=%0d want 1/0", wbuf_empty, wbuf_count); end
    idle_inputs();
    for (int i = 0; i < 3; i++) begin push_set(3'b100, a[i], 4'hF, rand_line()); tick(); end
    push_valid = 1'b0; wr_rdy = 1'b1;
    tick();
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (wr_req !== 1'b0 || wbuf_count !== 3'd0) begin
      n_fail++; $display("FAIL reset_mid_drain: got req=%0b count=%0d want 0/0", wr_req, wbuf_count); end
    q.delete();
    idle_inputs();
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_random();
    logic       h, f;
    logic [31:0] d;
    apply_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      push_valid = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0: push_type = 3'b000;
        1: push_type = 3'b001;
        2: push_type = 3'b010;
        default: push_type = 3'b100;
      endcase
      push_addr   = 32'h3000_0000 + 32'($urandom_range(0, 7)) * 32'h10 + 32'($urandom_range(0, 15));
      push_wstrb  = 4'($urandom);
      push_data   = rand_line();
      wr_rdy      = ($urandom_range(0, 2) == 0);
      flush       = ($urandom_range(0, 9) == 0);
      lookup_addr = 32'h3000_0000 + 32'($urandom_range(0, 8)) * 32'h10 + 32'($urandom_range(0, 15));
      #1;
      model_lookup(lookup_addr, h, f, d);
      n_checks++; if (wbuf_count !== 3'(q.size()) || wr_req !== (q.size() != 0)) begin
        n_fail++; $display("FAIL rand_count c%0d: got count=%0d req=%0b want %0d", cyc, wbuf_count, wr_req, q.size()); end
      n_checks++; if (push_ready !== ((q.size() < DEPTH) && !flush)) begin
        n_fail++; $display("FAIL rand_ready c%0d: got %0b", cyc, push_ready); end
      if (q.size() != 0) begin
        n_checks++; if (wr_addr !== q[0].a || wr_type !== q[0].t || wr_wstrb !== q[0].s || wr_data !== q[0].d) begin
          n_fail++; $display("FAIL rand_head c%0d: got addr=%h type=%b want %h/%b", cyc, wr_addr, wr_type, q[0].a, q[0].t); end
      end
      n_checks++; if (lookup_hit !== h || lookup_fwd !== f || lookup_data !== d) begin
        n_fail++; $display("FAIL rand_lookup c%0d: got %0b/%0b/%h want %0b/%0b/%h", cyc, lookup_hit, lookup_fwd, lookup_data, h, f, d); end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_line();
    test_fill_drain();
    test_back_to_back();
    test_lookup();
    test_uncached();
    test_flush_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
